// File: rtl/i2c_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : i2c_pkg
// Brief   : Shared state encoding and protocol constants for the I2C target.
// Rev     : 1.0  initial release
// ============================================================================
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ADDR_ACK  = 3'd2,
    ST_RX_BYTE   = 3'd3,
    ST_RX_ACK    = 3'd4,
    ST_TX_BYTE   = 3'd5,
    ST_TX_ACK    = 3'd6,
    ST_WAIT_STOP = 3'd7
  } i2c_state_t;

  localparam logic I2C_ACK       = 1'b0;
  localparam logic I2C_NACK      = 1'b1;
  localparam int   I2C_BYTE_BITS = 8;

endpackage
`default_nettype wire

// File: rtl/i2c_line_filter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : i2c_line_filter
// Brief   : Synchroniser chain followed by a consecutive-sample glitch filter.
// Rev     : 1.0  initial release
// ============================================================================
module i2c_line_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic filt_o
);

  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   filt_q, filt_d;
  logic                   samp;

  assign samp = sync_q[SYNC_STAGES-1];

  // The filtered line only follows after FILTER_LEN samples in a row disagree.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], raw_i};
    filt_d = filt_q;
    cnt_d  = '0;
    if (samp != filt_q) begin
      if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
        filt_d = samp;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
      cnt_q  <= '0;
      filt_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign filt_o = filt_q;

endmodule
`default_nettype wire

// File: rtl/i2c_target_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : i2c_target_engine
// Brief   : I2C target byte engine; I2C_CLK_STRETCH_EN enables SCL stretching
//           on TX underrun instead of sending 8'hFF.
// Rev     : 1.0  initial release
// ============================================================================
module i2c_target_engine
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = 7'h3C,
  parameter int         SYNC_STAGES = 2,
  parameter int         FILTER_LEN  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       scl_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_nack,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       addressed,
  output logic       rw,
  output logic       start_det,
  output logic       stop_det,
  output logic       tx_underrun
);

`ifdef I2C_CLK_STRETCH_EN
  localparam bit STRETCH_EN = 1'b1;
`else
  localparam bit STRETCH_EN = 1'b0;
`endif

  logic scl_f, sda_f;

  i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .clk(clk), .reset(reset), .raw_i(scl_i), .filt_o(scl_f)
  );
  i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .clk(clk), .reset(reset), .raw_i(sda_i), .filt_o(sda_f)
  );

  i2c_state_t state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] hold_q, hold_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       scl_prev_q, sda_prev_q;
  logic       ack_ph_q, ack_ph_d;
  logic       nack_q, nack_d;
  logic       load_pend_q, load_pend_d;
  logic       stretch_q, stretch_d;
  logic       hold_full_q, hold_full_d;
  logic       sda_oe_q, sda_oe_d;
  logic       scl_oe_q, scl_oe_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_ready_q, tx_ready_d;
  logic       addressed_q, addressed_d;
  logic       rw_q, rw_d;
  logic       start_det_q, start_det_d;
  logic       stop_det_q, stop_det_d;
  logic       tx_underrun_q, tx_underrun_d;

  logic       scl_rise, scl_fall, bus_start, bus_stop, tx_hs, load_fall;
  logic [7:0] rx_byte, load_src;

  assign scl_rise  = scl_f & ~scl_prev_q;
  assign scl_fall  = ~scl_f & scl_prev_q;
  assign bus_start = scl_f & scl_prev_q & sda_prev_q & ~sda_f;
  assign bus_stop  = scl_f & scl_prev_q & ~sda_prev_q & sda_f;
  assign tx_hs     = tx_valid & tx_ready_q;
  assign rx_byte   = {shift_q[6:0], sda_f};
  // A handshake landing on the load fall bypasses the holding register.
  assign load_src  = tx_hs ? tx_data : hold_q;
  assign load_fall = scl_fall &
                     (((state_q == ST_ADDR_ACK) & ack_ph_q & rw_q) |
                      ((state_q == ST_TX_BYTE) & load_pend_q & ~stretch_q));

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    ack_ph_d      = ack_ph_q;
    nack_d        = nack_q;
    load_pend_d   = load_pend_q;
    stretch_d     = stretch_q;
    sda_oe_d      = sda_oe_q;
    scl_oe_d      = scl_oe_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    addressed_d   = addressed_q;
    rw_d          = rw_q;
    start_det_d   = 1'b0;
    stop_det_d    = 1'b0;
    tx_underrun_d = 1'b0;
    tx_ready_d    = tx_ready_q;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;

    if (tx_hs) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
      tx_ready_d  = 1'b0;
    end

    if (bus_start || bus_stop) begin
      state_d     = bus_start ? ST_ADDR : ST_IDLE;
      bit_cnt_d   = '0;
      ack_ph_d    = 1'b0;
      load_pend_d = 1'b0;
      stretch_d   = 1'b0;
      sda_oe_d    = 1'b0;
      scl_oe_d    = 1'b0;
      addressed_d = 1'b0;
      tx_ready_d  = 1'b0;
      hold_full_d = 1'b0;
      start_det_d = bus_start;
      stop_det_d  = bus_stop;
    end else begin
      case (state_q)
        ST_ADDR: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == 4'(I2C_BYTE_BITS - 1)) begin
              ack_ph_d = 1'b0;
              if (shift_q[6:0] == DEV_ADDR) begin
                rw_d    = sda_f;
                state_d = ST_ADDR_ACK;
              end else begin
                state_d = ST_WAIT_STOP;
              end
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            if (!ack_ph_q) begin
              sda_oe_d    = 1'b1;
              addressed_d = 1'b1;
              ack_ph_d    = 1'b1;
              if (rw_q) tx_ready_d = 1'b1;
            end else if (!rw_q) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              state_d   = ST_RX_BYTE;
            end
          end
        end
        ST_RX_BYTE: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == 4'(I2C_BYTE_BITS - 1)) begin
              rx_data_d  = rx_byte;
              rx_valid_d = 1'b1;
              nack_d     = rx_nack;
              ack_ph_d   = 1'b0;
              state_d    = ST_RX_ACK;
            end
          end
        end
        ST_RX_ACK: begin
          if (scl_fall) begin
            if (!ack_ph_q) begin
              sda_oe_d = (nack_q == I2C_ACK);
              ack_ph_d = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              state_d   = ST_RX_BYTE;
            end
          end
        end
        ST_TX_BYTE: begin
          if (STRETCH_EN && stretch_q) begin
            if (tx_hs) begin
              shift_d     = tx_data;
              sda_oe_d    = ~tx_data[7];
              bit_cnt_d   = '0;
              scl_oe_d    = 1'b0;
              stretch_d   = 1'b0;
              load_pend_d = 1'b0;
              hold_full_d = 1'b0;
              tx_ready_d  = 1'b1;
            end
          end else if (!load_pend_q) begin
            if (scl_rise) begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end else if (scl_fall) begin
              if (bit_cnt_q == 4'(I2C_BYTE_BITS)) begin
                sda_oe_d = 1'b0;
                state_d  = ST_TX_ACK;
              end else begin
                sda_oe_d = ~shift_q[6];
                shift_d  = {shift_q[6:0], 1'b0};
              end
            end
          end
        end
        ST_TX_ACK: begin
          if (scl_rise) begin
            if (sda_f == I2C_ACK) begin
              load_pend_d = 1'b1;
              state_d     = ST_TX_BYTE;
            end else begin
              sda_oe_d   = 1'b0;
              tx_ready_d = 1'b0;
              state_d    = ST_WAIT_STOP;
            end
          end
        end
        default: ;
      endcase

      if (load_fall) begin
        state_d     = ST_TX_BYTE;
        bit_cnt_d   = '0;
        load_pend_d = 1'b0;
        tx_ready_d  = 1'b1;
        if (tx_hs || hold_full_q) begin
          shift_d     = load_src;
          sda_oe_d    = ~load_src[7];
          hold_full_d = 1'b0;
        end else if (STRETCH_EN) begin
          sda_oe_d    = 1'b0;
          scl_oe_d    = 1'b1;
          stretch_d   = 1'b1;
          load_pend_d = 1'b1;
        end else begin
          shift_d       = 8'hFF;
          sda_oe_d      = 1'b0;
          tx_underrun_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      hold_q        <= '0;
      rx_data_q     <= '0;
      scl_prev_q    <= 1'b1;
      sda_prev_q    <= 1'b1;
      ack_ph_q      <= 1'b0;
      nack_q        <= 1'b0;
      load_pend_q   <= 1'b0;
      stretch_q     <= 1'b0;
      hold_full_q   <= 1'b0;
      sda_oe_q      <= 1'b0;
      scl_oe_q      <= 1'b0;
      rx_valid_q    <= 1'b0;
      tx_ready_q    <= 1'b0;
      addressed_q   <= 1'b0;
      rw_q          <= 1'b0;
      start_det_q   <= 1'b0;
      stop_det_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      hold_q        <= hold_d;
      rx_data_q     <= rx_data_d;
      scl_prev_q    <= scl_f;
      sda_prev_q    <= sda_f;
      ack_ph_q      <= ack_ph_d;
      nack_q        <= nack_d;
      load_pend_q   <= load_pend_d;
      stretch_q     <= stretch_d;
      hold_full_q   <= hold_full_d;
      sda_oe_q      <= sda_oe_d;
      scl_oe_q      <= scl_oe_d;
      rx_valid_q    <= rx_valid_d;
      tx_ready_q    <= tx_ready_d;
      addressed_q   <= addressed_d;
      rw_q          <= rw_d;
      start_det_q   <= start_det_d;
      stop_det_q    <= stop_det_d;
      tx_underrun_q <= tx_underrun_d;
    end
  end

  assign sda_oe      = sda_oe_q;
  assign scl_oe      = STRETCH_EN ? scl_oe_q : 1'b0;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_ready    = tx_ready_q;
  assign addressed   = addressed_q;
  assign rw          = rw_q;
  assign start_det   = start_det_q;
  assign stop_det    = stop_det_q;
  assign tx_underrun = tx_underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_target_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_i2c_target_engine
// Brief   : Bus-master model driving randomized I2C transactions at the engine.
// Rev     : 1.0  initial release
// ============================================================================
module tb_i2c_target_engine;
  import i2c_pkg::*;

  typedef logic [7:0] bq_t[$];
  typedef bit         nq_t[$];

  localparam int Q = 8;  // quarter SCL period in clk cycles

  logic       clk = 1'b0;
  logic       reset;
  logic       scl_m, sda_m;
  logic       scl_i, sda_i;
  logic       sda_oe, scl_oe, rx_valid, rx_nack, tx_valid, tx_ready;
  logic       addressed, rw, start_det, stop_det, tx_underrun;
  logic [7:0] rx_data, tx_data;

  int checks = 0;
  int errors = 0;

  int   n_start = 0, n_stop = 0, n_under = 0, n_sda_oe = 0, n_scl_oe = 0;
  bq_t  rxq;
  bq_t  txq;
  int   tx_delay = 0;
  bit   tx_gate_stretch = 1'b0;
  int   tx_wait = 0;

  always #5 clk = ~clk;

  // Open-drain wiring: either side can pull a line low.
  assign scl_i = scl_m & ~scl_oe;
  assign sda_i = sda_m & ~sda_oe;

  i2c_target_engine #(.DEV_ADDR(7'h3C), .SYNC_STAGES(2), .FILTER_LEN(3)) dut (
    .clk(clk), .reset(reset), .scl_i(scl_i), .sda_i(sda_i),
    .sda_oe(sda_oe), .scl_oe(scl_oe), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_nack(rx_nack), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .addressed(addressed), .rw(rw), .start_det(start_det), .stop_det(stop_det),
    .tx_underrun(tx_underrun)
  );

  always @(negedge clk) begin
    if (start_det)   n_start++;
    if (stop_det)    n_stop++;
    if (tx_underrun) n_under++;
    if (sda_oe)      n_sda_oe++;
    if (scl_oe)      n_scl_oe++;
    if (rx_valid)    rxq.push_back(rx_data);
  end

  // Application side supplying TX bytes whenever the engine asks.
  initial begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (tx_valid) begin
        tx_valid = 1'b0;
      end else if (tx_ready && txq.size() > 0 && (!tx_gate_stretch || scl_oe)) begin
        if (tx_wait < tx_delay) begin
          tx_wait++;
        end else begin
          tx_data  = txq.pop_front();
          tx_valid = 1'b1;
          tx_wait  = 0;
        end
      end
    end
  end

  initial begin
    #800us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic scl_high();
    int t;
    t = 0;
    scl_m = 1'b1;
    @(negedge clk);
    while (scl_i !== 1'b1 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (scl_i !== 1'b1) begin
      errors++;
      $display("FAIL scl_release: scl_i=%b after %0d cycles, required 1", scl_i, t);
    end
  endtask

  task automatic write_bit(input bit b);
    sda_m = b;
    wait_clk(Q);
    scl_high();
    wait_clk(2 * Q);
    scl_m = 1'b0;
    wait_clk(Q);
  endtask

  task automatic write_bit_glitch(input bit b);
    sda_m = b;
    wait_clk(Q);
    scl_high();
    wait_clk(Q);
    sda_m = ~b;
    wait_clk(1);
    sda_m = b;
    wait_clk(Q - 1);
    scl_m = 1'b0;
    wait_clk(Q);
  endtask

  task automatic read_bit(output bit b);
    sda_m = 1'b1;
    wait_clk(Q);
    scl_high();
    wait_clk(Q);
    b = sda_i;
    wait_clk(Q);
    scl_m = 1'b0;
    wait_clk(Q);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    wait_clk(Q);
    scl_high();
    wait_clk(Q);
    sda_m = 1'b0;
    wait_clk(Q);
    scl_m = 1'b0;
    wait_clk(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    wait_clk(Q);
    scl_high();
    wait_clk(Q);
    sda_m = 1'b1;
    wait_clk(2 * Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output bit ack);
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    read_bit(ack);
  endtask

  task automatic recv_byte(output logic [7:0] b, input bit master_nack);
    bit x;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      read_bit(x);
      b = {b[6:0], x};
    end
    write_bit(master_nack);
  endtask

  // Full write transaction checked against the protocol rules: only our
  // address is acknowledged, and every byte to it appears on rx_data in order.
  task automatic write_txn(input logic [6:0] addr, input bq_t bytes, input nq_t nacks);
    bit   ack, match;
    int   s0, p0;
    match = (addr == 7'h3C);
    rxq.delete();
    s0 = n_start;
    p0 = n_stop;
    i2c_start();
    send_byte({addr, 1'b0}, ack);
    checks++;
    if (ack !== !match) begin
      errors++;
      $display("FAIL addr_ack: addr=%h got %b, required %b", addr, ack, !match);
    end
    checks++;
    if (addressed !== match) begin
      errors++;
      $display("FAIL addressed_after_ack: got %b, required %b", addressed, match);
    end
    foreach (bytes[i]) begin
      rx_nack = nacks[i];
      send_byte(bytes[i], ack);
      checks++;
      if (ack !== (match ? nacks[i] : 1'b1)) begin
        errors++;
        $display("FAIL data_ack[%0d]: got %b, required %b", i, ack, match ? nacks[i] : 1'b1);
      end
    end
    rx_nack = 1'b0;
    i2c_stop();
    checks++;
    if (rxq.size() !== (match ? bytes.size() : 0)) begin
      errors++;
      $display("FAIL rx_count: got %0d, required %0d", rxq.size(), match ? bytes.size() : 0);
    end else if (match) begin
      foreach (bytes[i]) begin
        checks++;
        if (rxq[i] !== bytes[i]) begin
          errors++;
          $display("FAIL rx_data[%0d]: got %h, required %h", i, rxq[i], bytes[i]);
        end
      end
    end
    checks++;
    if (n_start - s0 !== 1 || n_stop - p0 !== 1) begin
      errors++;
      $display("FAIL start_stop_count: got %0d/%0d, required 1/1", n_start - s0, n_stop - p0);
    end
    checks++;
    if (addressed !== 1'b0) begin
      errors++;
      $display("FAIL addressed_after_stop: got %b, required 0", addressed);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    scl_m = 1'b1;
    sda_m = 1'b1;
    rx_nack = 1'b0;
    wait_clk(4);
    checks++;
    if ({sda_oe, scl_oe, rx_valid, tx_ready, addressed, rw, start_det, stop_det,
         tx_underrun, rx_data} !== 17'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, required all 0",
               {sda_oe, scl_oe, rx_valid, tx_ready, addressed, rw, start_det, stop_det, tx_underrun, rx_data});
    end
    reset = 1'b0;
    wait_clk(10);
    checks++;
    if ({sda_oe, start_det, stop_det, addressed} !== 4'd0 || n_start !== 0 || n_stop !== 0) begin
      errors++;
      $display("FAIL idle_after_reset: outputs %b starts %0d stops %0d, required 0",
               {sda_oe, start_det, stop_det, addressed}, n_start, n_stop);
    end
  endtask

  task automatic test_write();
    bq_t b;
    nq_t n;
    b = '{8'hA5, 8'h5A};
    n = '{1'b0, 1'b0};
    write_txn(7'h3C, b, n);
    b.delete();
    n.delete();
    for (int i = 0; i < int'($urandom_range(2, 4)); i++) begin
      b.push_back(8'($urandom));
      n.push_back(1'($urandom_range(0, 1)));
    end
    write_txn(7'h3C, b, n);
  endtask

  task automatic test_addr_mismatch();
    bq_t        b;
    nq_t        n;
    int         oe0;
    logic [6:0] a;
    b = '{8'h11};
    n = '{1'b0};
    for (int k = 0; k < 2; k++) begin
      a = (k == 0) ? 7'h3D : 7'($urandom_range(0, 127));
      if (a == 7'h3C) a = 7'h3B;
      oe0 = n_sda_oe;
      write_txn(a, b, n);
      checks++;
      if (n_sda_oe !== oe0) begin
        errors++;
        $display("FAIL mismatch_sda_oe: asserted %0d cycles, required 0", n_sda_oe - oe0);
      end
    end
    b = '{8'($urandom)};
    write_txn(7'h3C, b, n);
  endtask

  task automatic test_read();
    bit          ack;
    logic [7:0]  got;
    bq_t         exp;
    int          nb;
    tx_delay = 0;
    for (int pass = 0; pass < 2; pass++) begin
      exp.delete();
      if (pass == 0) exp = '{8'hC3, 8'h3C};
      else begin
        nb = $urandom_range(1, 4);
        for (int i = 0; i < nb; i++) exp.push_back(8'($urandom));
      end
      txq = exp;
      i2c_start();
      send_byte({7'h3C, 1'b1}, ack);
      checks++;
      if (ack !== 1'b0 || rw !== 1'b1) begin
        errors++;
        $display("FAIL read_addr: ack=%b rw=%b, required 0/1", ack, rw);
      end
      foreach (exp[i]) begin
        recv_byte(got, i == exp.size() - 1);
        checks++;
        if (got !== exp[i]) begin
          errors++;
          $display("FAIL read_byte[%0d]: got %h, required %h", i, got, exp[i]);
        end
      end
      wait_clk(2 * Q);
      checks++;
      if (tx_ready !== 1'b0 || sda_oe !== 1'b0 || dut.state_q !== ST_WAIT_STOP) begin
        errors++;
        $display("FAIL read_nack_end: tx_ready=%b sda_oe=%b state=%0d, required 0/0/%0d",
                 tx_ready, sda_oe, dut.state_q, ST_WAIT_STOP);
      end
      i2c_stop();
    end
  endtask

  task automatic test_underrun();
    bit         ack;
    logic [7:0] got, want;
    int         u0, so0;
    u0  = n_under;
    so0 = n_scl_oe;
`ifdef I2C_CLK_STRETCH_EN
    want            = 8'hB7;
    txq             = '{8'hB7};
    tx_gate_stretch = 1'b1;
    tx_delay        = 50;
`else
    want = 8'hFF;
    txq.delete();
`endif
    i2c_start();
    send_byte({7'h3C, 1'b1}, ack);
    recv_byte(got, 1'b1);
    i2c_stop();
    tx_gate_stretch = 1'b0;
    tx_delay        = 0;
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL underrun_byte: got %h, required %h", got, want);
    end
`ifdef I2C_CLK_STRETCH_EN
    checks++;
    if (n_under - u0 !== 0 || n_scl_oe - so0 < 50) begin
      errors++;
      $display("FAIL stretch: underruns %0d stretch cycles %0d, required 0 and >=50",
               n_under - u0, n_scl_oe - so0);
    end
`else
    checks++;
    if (n_under - u0 !== 1 || n_scl_oe - so0 !== 0) begin
      errors++;
      $display("FAIL underrun_pulse: underruns %0d scl_oe cycles %0d, required 1 and 0",
               n_under - u0, n_scl_oe - so0);
    end
`endif
  endtask

  task automatic test_repeated_start();
    bit         ack;
    logic [7:0] d, e, got;
    int         s0, p0;
    d = 8'($urandom);
    e = 8'($urandom);
    rxq.delete();
    s0 = n_start;
    p0 = n_stop;
    i2c_start();
    send_byte({7'h3C, 1'b0}, ack);
    send_byte(d, ack);
    checks++;
    if (ack !== 1'b0 || rw !== 1'b0) begin
      errors++;
      $display("FAIL rs_write_phase: ack=%b rw=%b, required 0/0", ack, rw);
    end
    txq = '{e};
    i2c_start();
    send_byte({7'h3C, 1'b1}, ack);
    checks++;
    if (ack !== 1'b0 || rw !== 1'b1 || n_start - s0 !== 2 || n_stop !== p0) begin
      errors++;
      $display("FAIL rs_read_phase: ack=%b rw=%b starts=%0d stops=%0d, required 0/1/2/0",
               ack, rw, n_start - s0, n_stop - p0);
    end
    recv_byte(got, 1'b1);
    i2c_stop();
    checks++;
    if (got !== e || rxq.size() !== 1 || rxq[0] !== d) begin
      errors++;
      $display("FAIL rs_data: read %h (req %h) rx count %0d (req 1)", got, e, rxq.size());
    end
  endtask

  task automatic test_glitch();
    bit         ack;
    logic [7:0] d;
    int         s0, p0;
    d  = 8'($urandom) | 8'h81;
    d  = d & 8'hBD;
    s0 = n_start;
    p0 = n_stop;
    rxq.delete();
    sda_m = 1'b0;
    wait_clk(1);
    sda_m = 1'b1;
    wait_clk(20);
    checks++;
    if (n_start !== s0 || n_stop !== p0) begin
      errors++;
      $display("FAIL idle_glitch: starts %0d stops %0d, required 0/0", n_start - s0, n_stop - p0);
    end
    i2c_start();
    send_byte({7'h3C, 1'b0}, ack);
    for (int i = 7; i >= 0; i--) write_bit_glitch(d[i]);
    read_bit(ack);
    checks++;
    if (ack !== 1'b0 || n_start - s0 !== 1 || n_stop !== p0) begin
      errors++;
      $display("FAIL data_glitch: ack=%b starts=%0d stops=%0d, required 0/1/0",
               ack, n_start - s0, n_stop - p0);
    end
    i2c_stop();
    checks++;
    if (rxq.size() !== 1 || rxq[0] !== d) begin
      errors++;
      $display("FAIL glitch_rx: count %0d, required 1 byte %h", rxq.size(), d);
    end
  endtask

  task automatic test_reset_mid_byte();
    bq_t b;
    nq_t n;
    i2c_start();
    for (int i = 7; i >= 0; i--) write_bit(i == 0 ? 1'b0 : 1'(7'h3C >> (i - 1)));
    checks++;
    if (sda_oe !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_ack: sda_oe=%b, required 1", sda_oe);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({sda_oe, scl_oe, rx_valid, tx_ready, addressed, rw, start_det, stop_det,
         tx_underrun, rx_data} !== 17'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %b, required all 0",
               {sda_oe, scl_oe, rx_valid, tx_ready, addressed, rw, start_det, stop_det, tx_underrun, rx_data});
    end
    wait_clk(3);
    reset = 1'b0;
    wait_clk(4);
    i2c_stop();
    b = '{8'($urandom)};
    n = '{1'b0};
    write_txn(7'h3C, b, n);
  endtask

  initial begin
    test_reset();
    test_write();
    test_addr_mismatch();
    test_read();
    test_underrun();
    test_repeated_start();
    test_glitch();
    test_reset_mid_byte();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2c_target_engine.md
Name: i2c_target_engine

Overview:
Parametrised I2C target (slave) byte engine, the successor to the bit-level bus interface. Adds several functions:
- input synchronisation and glitch filtering
- 7-bit address match and R/W decode
- automatic ACK/NACK generation
- repeated-START handling
- valid/ready byte handshakes
Sits between the open-drain pad cells and the LED-driver register controller.

Parameters:
DEV_ADDR, 7'h3C, 7-bit target address compared against the address byte
SYNC_STAGES, 2, flops in the scl_i/sda_i synchronisers (min 2)
FILTER_LEN, 3, consecutive equal synchronised samples required before the filtered line changes (1 = no filtering)

Ports:
clk  in  1  system clock, at least 16x SCL
reset  in  1  asynchronous, active-high reset
scl_i  in  1  raw SCL from pad
sda_i  in  1  raw SDA from pad
sda_oe  out  1  1 = pull SDA low (pad drives 0), 0 = release
scl_oe  out  1  1 = hold SCL low (clock stretch)
rx_data  out  8  last received data byte
rx_valid  out  1  one-cycle pulse, rx_data updated
rx_nack  in  1  sampled with rx_valid; 1 = NACK this byte
tx_data  in  8  byte to send on a read
tx_valid  in  1  tx_data valid
tx_ready  out  1  engine holding register empty during a read
addressed  out  1  high from address ACK until STOP/repeated START
rw  out  1  R/W bit of current transaction (1 = read)
start_det  out  1  one-cycle pulse on START or repeated START
stop_det  out  1  one-cycle pulse on STOP
tx_underrun  out  1  one-cycle pulse when a TX byte starts with holding register empty

Behaviour:
- Reset values:
  - all outputs 0, including tx_ready
  - filtered lines = 1
  - state IDLE
- Line conditioning:
  - raw lines pass through SYNC_STAGES flops, then the FILTER_LEN filter.
  - All edge/START/STOP detection uses the filtered lines and their registered previous values.
  - Detection latency is SYNC_STAGES+FILTER_LEN clk cycles.
- Bus conditions:
  - START = filtered SDA 1->0 while filtered SCL=1.
  - STOP = filtered SDA 0->1 while filtered SCL=1.
- Bit timing: data is sampled on the SCL rising edge; sda_oe changes only on the SCL falling edge.
- States: IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, WAIT_STOP.
- START (any state) -> ADDR:
  - bit counter cleared, start_det pulses
  - addressed cleared, tx_ready cleared
- STOP (any state) -> IDLE:
  - sda_oe=0, scl_oe=0
  - stop_det pulses, addressed and tx_ready cleared
- ADDR: shift 8 bits MSB first.
  - On the 8th rise, compare bits[7:1] with DEV_ADDR.
  - Match: latch rw=bit0 -> ADDR_ACK.
  - Mismatch -> WAIT_STOP with sda_oe kept 0.
- ADDR_ACK:
  - Assert sda_oe at the next SCL fall; release it at the following fall.
  - Set addressed at the ACK fall.
  - If rw=1: tx_ready=1 from the ACK fall; the next state is TX_BYTE, otherwise RX_BYTE.
- RX_BYTE:
  - On the 8th rise: update rx_data, pulse rx_valid (same cycle), sample rx_nack -> RX_ACK.
  - RX_ACK drives sda_oe=!rx_nack for the 9th clock (fall to fall), then -> RX_BYTE.
  - A byte in progress when START/STOP arrives is discarded, with no rx_valid.
- TX holding register: handshake completes on tx_valid && tx_ready; the next cycle sets tx_ready=0.
- TX_BYTE:
  - At the SCL fall that begins the byte, load the shift register from the holding register and set tx_ready=1.
  - If the holding register is empty: load 8'hFF and pulse tx_underrun (default build).
  - Drive sda_oe = !bit, MSB first, updated on each fall.
  - Release SDA at the fall after the 8th bit -> TX_ACK.
- TX_ACK: sample SDA on the 9th rise.
  - 0 (ACK) -> TX_BYTE.
  - 1 (NACK) -> WAIT_STOP, tx_ready=0, sda_oe=0.
- WAIT_STOP: ignore all traffic until START or STOP.
- Simultaneous events:
  - START/STOP take priority over any SCL edge in the same cycle.
  - The tx handshake and the TX-load fall in the same cycle take the new data.

Optional Feature:
Macro I2C_CLK_STRETCH_EN.
- Defined: at the TX-load fall with the holding register empty, assert scl_oe and hold the engine. When the handshake completes, load the byte, release scl_oe the next cycle, and pulse no tx_underrun. RX_ACK likewise stretches while rx_nack is unknown: never.
- Undefined: scl_oe is tied 0; underrun sends 8'hFF as above.

Decomposition:
- Package i2c_pkg holds:
  - state enum typedef i2c_state_t
  - I2C_ACK=1'b0, I2C_NACK=1'b1
  - I2C_BYTE_BITS=8
- Sub-module i2c_line_filter: synchroniser + FILTER_LEN filter, with parameters SYNC_STAGES/FILTER_LEN, reset output 1. Instanced once each for SCL and SDA.

Test Plan:
- Write to 0x3C, data 0xA5, 0x5A, STOP:
  - sda_oe low in each 9th clock
  - rx_valid twice with rx_data 0xA5 then 0x5A
  - stop_det once; addressed=0 after STOP
- Address 0x3D, write 0x11:
  - sda_oe never asserts, no rx_valid
  - engine ignores data until STOP, then responds to the next 0x3C transaction
- Read from 0x3C with tx_data 0xC3 and 0x3C preloaded via handshake; master ACKs the first byte and NACKs the second:
  - SDA shows 0xC3 then 0x3C
  - state reaches WAIT_STOP, tx_ready=0
- Read with no tx_valid:
  - default build: 0xFF on the bus and a tx_underrun pulse
  - I2C_CLK_STRETCH_EN: scl_oe high until tx_valid arrives 50 cycles later, then 0xB7 sent
- Write 0x3C, byte 0x20, repeated START, read 0x3C:
  - start_det twice, rw changes 0->1, no STOP needed
- 1-cycle SDA glitch while SCL high with FILTER_LEN=3 -> no start_det/stop_det. Separately, assert reset mid-byte -> all outputs 0, sda_oe released immediately.
